esc_pwm_driver: RTL and testbench
=================================

ESC_PWM_DRIVER -- requirements
Module: esc_pwm_driver

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 500, giving clk cycles per duty step (minimum 2).
REQ-002 The block SHALL have parameter ARM_PERIODS, default 50, giving the number of full PWM periods held at idle duty before arming (minimum 1).
REQ-003 The block SHALL have parameter IDLE_DUTY, default 8'h32, giving the idle duty (50 %) the ESC requires.
REQ-004 The block SHALL have parameter SLEW_STEP, default 5, giving the maximum duty change per period when slew limiting is compiled in.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port duty_in, input, 8 bits: commanded duty, 8'h00 = 0 % to 8'h64 = 100 %.
REQ-008 The block SHALL have port duty_valid, input, 1 bit: single-cycle strobe qualifying duty_in.
REQ-009 The block SHALL have port enable, input, 1 bit: arm request; a low level disarms.
REQ-010 The block SHALL have port pwm_out, output, 1 bit: registered ESC drive.
REQ-011 The block SHALL have port armed, output, 1 bit: high only in state ARMED.
REQ-012 The block SHALL have port duty_active, output, 8 bits: duty currently applied to pwm_out.
REQ-013 The block SHALL have port period_start, output, 1 bit: one-cycle pulse at each period boundary.
REQ-014 The block SHALL have port sat_flag, output, 1 bit: one-cycle pulse when a sampled duty_in is clamped.

Function
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 and wrap; a tick is the cycle in which the count equals TICK_DIV-1.
REQ-016 The step counter SHALL advance once per tick over 0..99 and wrap from 99 to 0; period_start SHALL pulse in the cycle after the 99->0 wrap.
REQ-017 One PWM period SHALL therefore be exactly 100*TICK_DIV clk cycles.
REQ-018 pwm_out SHALL be registered (step < duty_active): duty 0 gives constant low and duty 100 gives constant high, with no glitch at the wrap.
REQ-019 On duty_valid, pending SHALL be loaded with min(duty_in, 100); when duty_in > 100, sat_flag SHALL pulse in the following cycle.
REQ-020 duty_active SHALL change only at the 99->0 wrap; a duty_valid in the wrap cycle itself SHALL take effect in the next period, not the current one.
REQ-021 Multiple duty_valid strobes within one period SHALL result in the last one winning.
REQ-022 The state machine SHALL have states DISARMED, ARMING and ARMED.
REQ-023 In DISARMED: pwm_out=0, duty_active=0, the prescaler, step counter and period counter held at 0; on enable=1 the state SHALL go to ARMING.
REQ-024 In ARMING: duty_active=IDLE_DUTY; after ARM_PERIODS completed wraps the state SHALL go to ARMED, applying pending at that same wrap.
REQ-025 In ARMED: duty_active SHALL follow pending at each wrap.
REQ-026 In any state, enable=0 SHALL force DISARMED on the next clock; pwm_out SHALL be 0 from that clock on, and pending SHALL reset to IDLE_DUTY.
REQ-027 pending SHALL retain values strobed during DISARMED or ARMING.

Reset
REQ-028 rst=1 at a clock edge SHALL set: state DISARMED, pwm_out=0, armed=0, duty_active=0, period_start=0, sat_flag=0, pending=IDLE_DUTY, all counters 0.
REQ-029 Reset SHALL take priority over enable and duty_valid, including in mid-period and mid-arming cycles.

Configuration
REQ-030 With ESC_SLEW_LIMIT_EN defined: in ARMED, each wrap SHALL move duty_active toward pending by at most SLEW_STEP, landing exactly on pending when within SLEW_STEP; the entry into ARMED SHALL start from IDLE_DUTY.
REQ-031 Without ESC_SLEW_LIMIT_EN defined: duty_active SHALL load pending directly at each wrap, and SLEW_STEP is unused.

Verification (TICK_DIV=2, ARM_PERIODS=2, period = 200 cycles)
REQ-032 Scenario 1: reset, then enable=1 -> pwm_out high 100 of every 200 cycles for 2 periods; armed rises at the 2nd wrap.
REQ-033 Scenario 2: armed, duty_in=8'h14 strobed mid-period -> the current period is unchanged; the next period is high for exactly 40 cycles.
REQ-034 Scenario 3: duty_in=8'hC8 -> sat_flag pulses once; the next period gives duty_active=100 and pwm_out constantly high; then duty_in=0 -> constantly low, with no single-cycle glitch.
REQ-035 Scenario 4: enable dropped mid-period -> pwm_out=0 and armed=0 on the next clock; re-enable -> the full 2-period arming sequence repeats.
REQ-036 Scenario 5: duty_valid coincident with the wrap cycle -> the value applies one period later; rst asserted mid-arming -> all outputs match the REQ-028 values on the next clock.
REQ-037 Scenario 6 (ESC_SLEW_LIMIT_EN defined): armed at 50, command 70 -> duty_active steps 55, 60, 65, 70 on successive wraps.

Source files
------------

// File: rtl/esc_pwm_driver.sv
// esc_pwm_driver: ESC PWM generator with arming sequence; optional slew limit via ESC_SLEW_LIMIT_EN
module esc_pwm_driver #(
  parameter int          TICK_DIV    = 500,
  parameter int          ARM_PERIODS = 50,
  parameter logic [7:0]  IDLE_DUTY   = 8'h32,
  parameter int          SLEW_STEP   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] duty_in,
  input  logic       duty_valid,
  input  logic       enable,
  output logic       pwm_out,
  output logic       armed,
  output logic [7:0] duty_active,
  output logic       period_start,
  output logic       sat_flag
);
  typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(ARM_PERIODS + 1);
  state_t state, nstate;
  logic [PW-1:0] presc, presc_n;
  logic [6:0] step, step_n;
  logic [CW-1:0] per_cnt, per_cnt_n;
  logic [7:0] pending, pending_n, duty_n, next_duty;
  logic tick, wrap, run;
  assign tick = state != DISARMED && presc == PW'(TICK_DIV - 1);
  assign wrap = tick && step == 7'd99;
  assign run  = state != DISARMED && nstate != DISARMED;
`ifdef ESC_SLEW_LIMIT_EN
  logic [7:0] diff;
  logic up;
  // move toward pending by at most SLEW_STEP per period, landing exactly when close
  always_comb begin
    up = pending > duty_active;
    diff = up ? pending - duty_active : duty_active - pending;
    next_duty = diff <= 8'(SLEW_STEP) ? pending : up ? duty_active + 8'(SLEW_STEP) : duty_active - 8'(SLEW_STEP);
  end
`else
  assign next_duty = pending;
`endif
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= DISARMED;
    else state <= nstate;
  end
  // next state: disarm dominates, arming completes on the last arming wrap
  always_comb begin
    nstate = state;
    if (!enable) nstate = DISARMED;
    else if (state == DISARMED) nstate = ARMING;
    else if (state == ARMING && wrap && per_cnt == CW'(ARM_PERIODS - 1)) nstate = ARMED;
  end
  // state-decoded output
  always_comb armed = state == ARMED;
  // next values for counters, duty and pending; counters sit at 0 whenever not running
  always_comb begin
    presc_n = (!run || tick) ? '0 : presc + 1'b1;
    step_n = !run ? '0 : tick ? (step == 7'd99 ? '0 : step + 7'd1) : step;
    per_cnt_n = !run ? '0 : (wrap && state == ARMING) ? per_cnt + 1'b1 : per_cnt;
    duty_n = nstate == DISARMED ? '0 : state == DISARMED ? IDLE_DUTY : (wrap && nstate == ARMED) ? next_duty : duty_active;
    pending_n = (state != DISARMED && !enable) ? IDLE_DUTY : duty_valid ? (duty_in > 8'd100 ? 8'd100 : duty_in) : pending;
  end
  // datapath registers; pwm_out is computed from next values so it stays aligned with step
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      step <= '0;
      per_cnt <= '0;
      pending <= IDLE_DUTY;
      duty_active <= '0;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      presc <= presc_n;
      step <= step_n;
      per_cnt <= per_cnt_n;
      pending <= pending_n;
      duty_active <= duty_n;
      pwm_out <= {1'b0, step_n} < duty_n;
      period_start <= wrap && run;
      sat_flag <= duty_valid && duty_in > 8'd100;
    end
  end
endmodule

// File: tb/tb_esc_pwm_driver.sv
// tb_esc_pwm_driver: directed, table-driven and random checks against a period-level model
module tb_esc_pwm_driver;
  localparam int TD = 2, AP = 2, IDLE = 50, SL = 5, PER = 100 * TD;
  logic clk = 1'b0, rst = 1'b1, duty_valid = 1'b0, enable = 1'b0;
  logic [7:0] duty_in = 8'd0;
  logic pwm_out, armed, period_start, sat_flag;
  logic [7:0] duty_active;
  int n_chk = 0, n_pass = 0, hc = 0, ncyc = 0;
  int m_st = 0, m_cyc = 0, m_per = 0, m_pend = IDLE, m_duty = 0;
  bit m_ps = 0, m_sat = 0;
  typedef struct {logic [7:0] din; int exp_duty; bit exp_sat;} vec_t;
  vec_t vecs[7];

  esc_pwm_driver #(.TICK_DIV(TD), .ARM_PERIODS(AP), .IDLE_DUTY(8'(IDLE)), .SLEW_STEP(SL)) dut (
    .clk(clk), .rst(rst), .duty_in(duty_in), .duty_valid(duty_valid), .enable(enable),
    .pwm_out(pwm_out), .armed(armed), .duty_active(duty_active),
    .period_start(period_start), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  function automatic int apply(int d, int p);
`ifdef ESC_SLEW_LIMIT_EN
    if (p > d + SL) return d + SL;
    if (p < d - SL) return d - SL;
`endif
    return p;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, ncyc);
  endtask

  // model state per clock edge: position in period, period count, pending, applied duty
  task automatic model();
    bit wrapc;
    int np;
    if (rst) begin
      m_st = 0; m_cyc = 0; m_per = 0; m_pend = IDLE; m_duty = 0; m_ps = 0; m_sat = 0;
      return;
    end
    m_sat = duty_valid && duty_in > 100;
    np = duty_valid ? (duty_in > 100 ? 100 : int'(duty_in)) : m_pend;
    wrapc = m_st != 0 && m_cyc == PER - 1;
    m_ps = wrapc && enable;
    if (!enable) begin
      if (m_st != 0) np = IDLE;
      m_st = 0; m_duty = 0; m_cyc = 0; m_per = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_duty = IDLE; m_cyc = 0; m_per = 0;
    end else if (wrapc) begin
      m_cyc = 0;
      m_per++;
      if (m_st == 2 || m_per == AP) begin
        m_st = 2;
        m_duty = apply(m_duty, m_pend);
      end
    end else m_cyc++;
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    ncyc++;
    hc += int'(pwm_out);
    check("pwm_out", pwm_out, (m_cyc / TD) < m_duty);
    check("armed", armed, m_st == 2);
    check("duty_active", duty_active, m_duty);
    check("period_start", period_start, m_ps);
    check("sat_flag", sat_flag, m_sat);
  endtask

  task automatic strobe(input logic [7:0] v);
    duty_in = v;
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int i = 0;
    do begin
      tick();
      i++;
    end while (!period_start && i < 2 * PER);
    check("wait_period_start", period_start, 1);
  endtask

  initial begin
    vecs = '{'{8'hC8, 100, 1}, '{8'h00, 0, 0}, '{8'h64, 100, 0}, '{8'h65, 100, 1},
             '{8'hFF, 100, 1}, '{8'h14, 20, 0}, '{8'h32, 50, 0}};
    tick();
    tick();
    check("rst_pwm", pwm_out, 0);
    check("rst_armed", armed, 0);
    check("rst_duty", duty_active, 0);
    check("rst_period_start", period_start, 0);
    check("rst_sat", sat_flag, 0);
    rst = 1'b0;
    tick();
    enable = 1'b1;
    hc = 0;
    repeat (PER) tick();
    check("s1_period1_high", hc, PER / 2);
    check("s1_armed_p1", armed, 0);
    hc = 0;
    repeat (PER) tick();
    check("s1_period2_high", hc, PER / 2);
    check("s1_armed_p2", armed, 0);
    hc = 0;
    tick();
    check("s1_armed_at_wrap", armed, 1);
    check("s1_period_start", period_start, 1);
    repeat (49) tick();
    strobe(8'h14);
    repeat (149) tick();
    check("s2_current_period_high", hc, PER / 2);
    hc = 0;
    repeat (PER) tick();
    check("s2_next_period_high", hc, TD * apply(IDLE, 20));
    for (int k = 0; k < 7; k++) begin
      strobe(vecs[k].din);
      check("vec_sat", sat_flag, vecs[k].exp_sat);
      tick();
      check("vec_sat_single", sat_flag, 0);
      for (int w = 0; w < 25 && duty_active != 8'(vecs[k].exp_duty); w++) wait_ps();
      check("vec_duty", duty_active, vecs[k].exp_duty);
      hc = 0;
      repeat (PER) tick();
      check("vec_period_high", hc, TD * vecs[k].exp_duty);
    end
`ifdef ESC_SLEW_LIMIT_EN
    strobe(8'd70);
    for (int k = 1; k <= 4; k++) begin
      wait_ps();
      check("s6_slew", duty_active, IDLE + SL * k);
    end
`endif
    repeat (70) tick();
    enable = 1'b0;
    tick();
    check("s4_pwm_off", pwm_out, 0);
    check("s4_disarmed", armed, 0);
    check("s4_duty_zero", duty_active, 0);
    repeat (5) tick();
    enable = 1'b1;
    hc = 0;
    repeat (2 * PER) tick();
    check("s4_rearm_high", hc, PER);
    check("s4_rearm_not_yet", armed, 0);
    tick();
    check("s4_rearmed", armed, 1);
    wait_ps();
    repeat (PER - 1) tick();
    strobe(8'd30);
    check("s5_wrap_strobe_ps", period_start, 1);
    check("s5_wrap_strobe_hold", duty_active, IDLE);
    wait_ps();
    check("s5_wrap_strobe_apply", duty_active, apply(IDLE, 30));
    enable = 1'b0;
    tick();
    enable = 1'b1;
    repeat (250) tick();
    rst = 1'b1;
    duty_in = 8'hC8;
    duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    rst = 1'b0;
    check("s5_rst_pwm", pwm_out, 0);
    check("s5_rst_armed", armed, 0);
    check("s5_rst_duty", duty_active, 0);
    check("s5_rst_period_start", period_start, 0);
    check("s5_rst_sat", sat_flag, 0);
    for (int i = 0; i < 20000; i++) begin
      rst = $urandom_range(0, 1999) == 0;
      enable = enable ? ($urandom_range(0, 2999) != 0) : ($urandom_range(0, 9) != 0);
      duty_valid = $urandom_range(0, 149) == 0;
      duty_in = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 100));
      tick();
    end
    duty_valid = 1'b0;
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
